// File: rtl/closest_hit_scheduler.sv
// Closest-hit scheduler: streams a triangle list through an external intersection
// unit for one ray and keeps the nearest strictly-positive hit.
// state  | meaning
// IDLE   | waiting for start (ignored while done is still high)
// FETCH  | trig_rd strobe for triangle idx
// LOAD   | capture vertices into ix_v1..ix_v3
// LAUNCH | ix_start pulse, arm timeout counter
// WAIT   | wait for ix_ready or timeout expiry
// UPDATE | closest-hit compare, advance idx
// DONE   | publish hit_t; done pulses on the following cycle
module closest_hit_scheduler #(
  parameter int         TRIG_AW  = 8,
  parameter int         TIMEOUT  = 1024,
  parameter logic [1:0] HIT_CODE = 2'd1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [191:0]         ray_in,
  input  logic [TRIG_AW:0]     trig_count,
  output logic                 trig_rd,
  output logic [TRIG_AW-1:0]   trig_addr,
  input  logic [287:0]         trig_data,
  output logic                 ix_start,
  output logic [191:0]         ix_ray,
  output logic [95:0]          ix_v1,
  output logic [95:0]          ix_v2,
  output logic [95:0]          ix_v3,
  input  logic                 ix_ready,
  input  logic [31:0]          ix_t,
  input  logic [1:0]           ix_code,
  output logic                 busy,
  output logic                 done,
  output logic                 hit,
  output logic [31:0]          hit_t,
  output logic [TRIG_AW-1:0]   hit_index,
  output logic                 err
);

  localparam int          CW    = $clog2(TIMEOUT + 1);
  localparam logic [31:0] T_MAX = 32'h7FFF_FFFF;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LOAD, S_LAUNCH, S_WAIT, S_UPDATE, S_DONE
  } state_t;

  state_t             state, state_nxt;
  logic [TRIG_AW-1:0] idx;
  logic [TRIG_AW:0]   count_q;
  logic [31:0]        best_t;
  logic [31:0]        cand_t;
  logic [1:0]         cand_code;
  logic               cand_valid;
  logic [CW-1:0]      tmo_cnt;
  logic               accept;
  logic               last_tri;
  logic               cand_hit;

  assign accept    = start && !done;
  assign last_tri  = ({1'b0, idx} == count_q - (TRIG_AW+1)'(1));
  assign trig_addr = idx;
  // A timed-out triangle leaves cand_valid low and can never win.
  assign cand_hit  = cand_valid && (cand_code == HIT_CODE) &&
                     ($signed(cand_t) > 32'sd0) && ($signed(cand_t) < $signed(best_t));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    trig_rd   = 1'b0;
    ix_start  = 1'b0;
    busy      = (state != S_IDLE) || done;
    unique case (state)
      S_IDLE:   if (accept) state_nxt = (trig_count == '0) ? S_DONE : S_FETCH;
      S_FETCH:  begin trig_rd = 1'b1; state_nxt = S_LOAD; end
      S_LOAD:   state_nxt = S_LAUNCH;
      S_LAUNCH: begin ix_start = 1'b1; state_nxt = S_WAIT; end
      S_WAIT:   if (ix_ready || tmo_cnt == '0) state_nxt = S_UPDATE;
      S_UPDATE: state_nxt = last_tri ? S_DONE : S_FETCH;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx        <= '0;
      count_q    <= '0;
      best_t     <= T_MAX;
      cand_t     <= '0;
      cand_code  <= '0;
      cand_valid <= 1'b0;
      tmo_cnt    <= '0;
      ix_ray     <= '0;
      ix_v1      <= '0;
      ix_v2      <= '0;
      ix_v3      <= '0;
      done       <= 1'b0;
      hit        <= 1'b0;
      hit_t      <= T_MAX;
      hit_index  <= '0;
      err        <= 1'b0;
    end else begin
      done <= (state == S_DONE);
      case (state)
        S_IDLE: if (accept) begin
          ix_ray  <= ray_in;
          count_q <= trig_count;
          idx     <= '0;
          best_t  <= T_MAX;
          hit     <= 1'b0;
          err     <= 1'b0;
        end
        S_LOAD:   {ix_v1, ix_v2, ix_v3} <= trig_data;
        S_LAUNCH: tmo_cnt <= CW'(TIMEOUT - 1);
        S_WAIT: begin
          if (ix_ready) begin
            cand_t     <= ix_t;
            cand_code  <= ix_code;
            cand_valid <= 1'b1;
          end else if (tmo_cnt == '0) begin
            cand_valid <= 1'b0;
            err        <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt - CW'(1);
          end
        end
        S_UPDATE: begin
          if (cand_hit) begin
            best_t    <= cand_t;
            hit_index <= idx;
            hit       <= 1'b1;
          end
          if (!last_tri) idx <= idx + TRIG_AW'(1);
        end
        S_DONE:   hit_t <= best_t;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_closest_hit_scheduler.sv
// Bench for closest_hit_scheduler: triangle memory and intersection-unit models
// driven from per-triangle tables, results compared to a closest-hit reference.
module tb_closest_hit_scheduler;
  localparam int          AW    = 8;
  localparam int          TMO   = 16;
  localparam logic [31:0] T_MAX = 32'h7FFF_FFFF;

  logic            clk, rst_n, start;
  logic [191:0]    ray_in;
  logic [AW:0]     trig_count;
  logic            trig_rd;
  logic [AW-1:0]   trig_addr;
  logic [287:0]    trig_data;
  logic            ix_start;
  logic [191:0]    ix_ray;
  logic [95:0]     ix_v1, ix_v2, ix_v3;
  logic            rsp_ready, stray_ready, ix_ready;
  logic [31:0]     ix_t;
  logic [1:0]      ix_code;
  logic            busy, done, hit, err;
  logic [31:0]     hit_t;
  logic [AW-1:0]   hit_index;

  assign ix_ready = rsp_ready | stray_ready;

  closest_hit_scheduler #(.TRIG_AW(AW), .TIMEOUT(TMO), .HIT_CODE(2'd1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ray_in(ray_in), .trig_count(trig_count),
    .trig_rd(trig_rd), .trig_addr(trig_addr), .trig_data(trig_data),
    .ix_start(ix_start), .ix_ray(ix_ray), .ix_v1(ix_v1), .ix_v2(ix_v2), .ix_v3(ix_v3),
    .ix_ready(ix_ready), .ix_t(ix_t), .ix_code(ix_code),
    .busy(busy), .done(done), .hit(hit), .hit_t(hit_t), .hit_index(hit_index), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Per-triangle tables: vertices, result latency (0 = never answers), t, code.
  logic [287:0] mem [256];
  int           lat [256];
  logic [31:0]  rt  [256];
  logic [1:0]   rc  [256];

  int checks, errors;
  int cyc, acc_cyc, op_bad, last_addr, wait_left;
  int rd_addr_q[$], rd_cyc_q[$], st_cyc_q[$], done_cyc_q[$];
  logic [191:0] cur_ray;

  // Data outside the read slot is garbage so mistimed captures show up.
  always @(posedge clk) begin
    if (trig_rd) trig_data <= mem[trig_addr];
    else         trig_data <= {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(),
                               $urandom(), $urandom(), $urandom(), $urandom()};
  end

  always @(posedge clk) begin
    if (start && !busy) begin
      rd_addr_q.delete(); rd_cyc_q.delete(); st_cyc_q.delete(); done_cyc_q.delete();
      op_bad  = 0;
      acc_cyc = cyc;
    end
    if (trig_rd) begin
      rd_addr_q.push_back(int'(trig_addr));
      rd_cyc_q.push_back(cyc);
      last_addr = int'(trig_addr);
    end
    if (ix_start) begin
      st_cyc_q.push_back(cyc);
      if (ix_ray !== cur_ray || {ix_v1, ix_v2, ix_v3} !== mem[last_addr]) op_bad++;
    end
    if (done) done_cyc_q.push_back(cyc);
    cyc++;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_left = 0;
      rsp_ready <= 1'b0;
      ix_t      <= '0;
      ix_code   <= '0;
    end else begin
      rsp_ready <= 1'b0;
      if (ix_start) wait_left = lat[last_addr];
      if (wait_left == 1) begin
        rsp_ready <= 1'b1;
        ix_t      <= rt[last_addr];
        ix_code   <= rc[last_addr];
      end
      if (wait_left > 0) wait_left--;
    end
  end

  logic          e_hit, e_err;
  logic [31:0]   e_t;
  logic [AW-1:0] e_idx;
  int            e_cycles;

  // Closest strictly-positive hit; earliest index wins ties; no answer within TMO is a miss.
  task automatic ref_scan(input int n);
    e_t = T_MAX; e_hit = 1'b0; e_err = 1'b0; e_idx = '0; e_cycles = 2;
    for (int i = 0; i < n; i++) begin
      if (lat[i] == 0 || lat[i] > TMO) begin
        e_err = 1'b1;
        e_cycles += 4 + TMO;
      end else begin
        e_cycles += 4 + lat[i];
        if (rc[i] == 2'd1 && $signed(rt[i]) > 0 && $signed(rt[i]) < $signed(e_t)) begin
          e_t = rt[i]; e_idx = AW'(i); e_hit = 1'b1;
        end
      end
    end
  endtask

  logic          o_hit, o_err, o_busy_done, o_busy_after, o_done_after, o_timeout;
  logic [31:0]   o_t;
  logic [AW-1:0] o_idx;
  int            o_cycles, o_busy_gap;

  function automatic logic [191:0] rand_ray();
    return {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic set_tri(input int i, input int l, input logic [31:0] t, input logic [1:0] c);
    lat[i] = l; rt[i] = t; rc[i] = c;
    mem[i] = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(),
              $urandom(), $urandom(), $urandom(), $urandom()};
  endtask

  // Runs one scan; a nonzero mid re-pulses start that many cycles into the scan.
  task automatic do_scan(input int n, input logic [191:0] ray, input int mid);
    cur_ray = ray;
    @(posedge clk); #1;
    ray_in = ray; trig_count = (AW+1)'(n); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; ray_in = rand_ray(); trig_count = (AW+1)'($urandom_range(0, 7));
    o_timeout = 1'b1; o_busy_gap = 0;
    for (int k = 0; k < 3000; k++) begin
      if (done) begin o_timeout = 1'b0; break; end
      if (!busy) o_busy_gap++;
      if (mid > 0 && k == mid) start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end
    o_hit = hit; o_t = hit_t; o_idx = hit_index; o_err = err; o_busy_done = busy;
    @(posedge clk); #1;
    o_done_after = done; o_busy_after = busy;
    o_cycles = (done_cyc_q.size() > 0) ? done_cyc_q[0] - acc_cyc : -1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; stray_ready = 1'b0; ray_in = '0; trig_count = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({trig_rd, trig_addr, ix_start, ix_ray, ix_v1, ix_v2, ix_v3, busy, done, hit, hit_index, err} !== '0) begin
      errors++; $display("FAIL reset_outputs: got nonzero outputs (busy=%b done=%b hit=%b err=%b)", busy, done, hit, err);
    end
    checks++;
    if (hit_t !== T_MAX) begin errors++; $display("FAIL reset_hit_t: got %h expected %h", hit_t, T_MAX); end
    rst_n = 1'b1;
  endtask

  task automatic test_zero_count();
    ref_scan(0);
    do_scan(0, rand_ray(), 0);
    checks++;
    if (o_timeout || o_cycles !== 2) begin errors++; $display("FAIL zero_latency: got %0d expected 2", o_cycles); end
    checks++;
    if ({o_hit, o_err} !== 2'b00 || o_t !== T_MAX) begin
      errors++; $display("FAIL zero_result: got hit=%b err=%b t=%h expected 0 0 %h", o_hit, o_err, o_t, T_MAX);
    end
    checks++;
    if (rd_cyc_q.size() != 0 || st_cyc_q.size() != 0) begin
      errors++; $display("FAIL zero_no_access: got %0d reads %0d launches expected 0 0", rd_cyc_q.size(), st_cyc_q.size());
    end
  endtask

  task automatic test_single_hit();
    logic [191:0] ray;
    set_tri(0, 3, 32'h0800_0000, 2'd1);
    mem[0] = {96'h0, 32'h2000_0000, 64'h0, 32'h0, 32'h2000_0000, 32'h0};
    ray = {32'h0800_0000, 32'h0800_0000, 32'h0800_0000, 32'h0, 32'h0, 32'hF000_0000};
    do_scan(1, ray, 0);
    checks++;
    if (o_timeout || {o_hit, o_err} !== 2'b10 || o_t !== 32'h0800_0000 || o_idx !== '0) begin
      errors++; $display("FAIL single_hit: got hit=%b err=%b t=%h idx=%0d expected 1 0 08000000 0", o_hit, o_err, o_t, o_idx);
    end
    checks++;
    if (o_cycles !== 9 || op_bad != 0) begin
      errors++; $display("FAIL single_timing: got %0d cycles %0d bad operands expected 9 0", o_cycles, op_bad);
    end
  endtask

  task automatic test_tie();
    set_tri(0, 2, 32'h2000_0000, 2'd1);
    set_tri(1, 4, 32'h0800_0000, 2'd1);
    set_tri(2, 1, 32'h0800_0000, 2'd1);
    do_scan(3, rand_ray(), 0);
    checks++;
    if (o_timeout || o_hit !== 1'b1 || o_t !== 32'h0800_0000 || o_idx !== AW'(1)) begin
      errors++; $display("FAIL tie_keeps_first: got hit=%b t=%h idx=%0d expected 1 08000000 1", o_hit, o_t, o_idx);
    end
    checks++;
    if (st_cyc_q.size() != 3 || rd_addr_q.size() != 3 ||
        (rd_addr_q.size() == 3 && (rd_addr_q[0] != 0 || rd_addr_q[1] != 1 || rd_addr_q[2] != 2))) begin
      errors++; $display("FAIL tie_sequence: got %0d launches %0d reads expected 3 launches, addrs 0,1,2", st_cyc_q.size(), rd_addr_q.size());
    end
  endtask

  task automatic test_misses();
    set_tri(0, 2, 32'h0100_0000, 2'd0);
    set_tri(1, 3, 32'h0100_0000, 2'd2);
    set_tri(2, 1, 32'h0000_0000, 2'd1);
    set_tri(3, 2, 32'h8000_0000, 2'd1);
    do_scan(4, rand_ray(), 0);
    checks++;
    if (o_timeout || {o_hit, o_err} !== 2'b00 || o_t !== T_MAX) begin
      errors++; $display("FAIL all_miss: got hit=%b err=%b t=%h expected 0 0 %h", o_hit, o_err, o_t, T_MAX);
    end
  endtask

  task automatic test_timeout();
    set_tri(0, 0, 32'h0100_0000, 2'd1);
    set_tri(1, 2, 32'h1000_0000, 2'd1);
    do_scan(2, rand_ray(), 0);
    checks++;
    if (o_timeout || {o_hit, o_err} !== 2'b11 || o_t !== 32'h1000_0000 || o_idx !== AW'(1)) begin
      errors++; $display("FAIL timeout_result: got hit=%b err=%b t=%h idx=%0d expected 1 1 10000000 1", o_hit, o_err, o_t, o_idx);
    end
    checks++;
    if (st_cyc_q.size() < 1 || rd_cyc_q.size() < 2 || rd_cyc_q[1] - st_cyc_q[0] != TMO + 2) begin
      errors++; $display("FAIL timeout_wait_len: got %0d launches %0d reads expected WAIT of %0d cycles", st_cyc_q.size(), rd_cyc_q.size(), TMO);
    end
  endtask

  task automatic test_random();
    int n, bad_addr;
    logic [31:0] t;
    for (int it = 0; it < 10; it++) begin
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) begin
        case ($urandom_range(0, 5))
          0: t = 32'h8000_0000 | $urandom();
          1: t = 32'h0;
          2: t = 32'h0100_0000 * $urandom_range(1, 3);
          3: t = $urandom() & T_MAX;
          4: t = T_MAX;
          default: t = 32'h0200_0000;
        endcase
        set_tri(i, ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 6), t, 2'($urandom_range(0, 3)));
      end
      ref_scan(n);
      do_scan(n, rand_ray(), 0);
      checks++;
      if (o_timeout || o_hit !== e_hit || o_t !== e_t || o_err !== e_err || (e_hit && o_idx !== e_idx)) begin
        errors++; $display("FAIL rand_result[%0d]: got hit=%b t=%h idx=%0d err=%b expected %b %h %0d %b",
                           it, o_hit, o_t, o_idx, o_err, e_hit, e_t, e_idx, e_err);
      end
      checks++;
      if (o_cycles != e_cycles) begin errors++; $display("FAIL rand_latency[%0d]: got %0d expected %0d", it, o_cycles, e_cycles); end
      bad_addr = (rd_addr_q.size() != n) ? 1 : 0;
      foreach (rd_addr_q[j]) if (rd_addr_q[j] != j) bad_addr++;
      checks++;
      if (bad_addr != 0 || st_cyc_q.size() != n || op_bad != 0) begin
        errors++; $display("FAIL rand_fetch[%0d]: got %0d reads %0d launches %0d bad operands expected %0d %0d 0",
                           it, rd_addr_q.size(), st_cyc_q.size(), op_bad, n, n);
      end
      checks++;
      if (o_busy_gap != 0 || o_busy_done !== 1'b1 || o_busy_after !== 1'b0 || o_done_after !== 1'b0 || done_cyc_q.size() != 1) begin
        errors++; $display("FAIL rand_handshake[%0d]: got gap=%0d busy@done=%b busy_after=%b done_after=%b done_pulses=%0d expected 0 1 0 0 1",
                           it, o_busy_gap, o_busy_done, o_busy_after, o_done_after, done_cyc_q.size());
      end
    end
  endtask

  task automatic test_reset_abort();
    int k;
    set_tri(0, 0, 32'h0100_0000, 2'd1);
    set_tri(1, 0, 32'h0100_0000, 2'd1);
    set_tri(2, 0, 32'h0100_0000, 2'd1);
    cur_ray = rand_ray();
    @(posedge clk); #1;
    ray_in = cur_ray; trig_count = (AW+1)'(3); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    k = 0;
    while (st_cyc_q.size() == 0 && k < 50) begin @(posedge clk); #1; k++; end
    checks++;
    if (st_cyc_q.size() == 0) begin errors++; $display("FAIL abort_launch: got 0 launches expected 1"); end
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({trig_rd, trig_addr, ix_start, ix_ray, ix_v1, ix_v2, ix_v3, busy, done, hit, hit_index, err} !== '0 || hit_t !== T_MAX) begin
      errors++; $display("FAIL abort_reset_values: got busy=%b done=%b hit_t=%h expected 0 0 %h", busy, done, hit_t, T_MAX);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1 stray_ready = 1'b1;
    @(posedge clk); #1 stray_ready = 1'b0;
    repeat (25) @(posedge clk);
    #1;
    checks++;
    if (done_cyc_q.size() != 0 || rd_cyc_q.size() != 1 || busy !== 1'b0) begin
      errors++; $display("FAIL abort_quiet: got %0d done pulses %0d reads busy=%b expected 0 1 0", done_cyc_q.size(), rd_cyc_q.size(), busy);
    end
    set_tri(0, 2, 32'h0300_0000, 2'd1);
    set_tri(1, 3, 32'h0100_0000, 2'd1);
    set_tri(2, 1, 32'h0200_0000, 2'd1);
    ref_scan(3);
    do_scan(3, rand_ray(), 5);
    checks++;
    if (o_timeout || o_hit !== 1'b1 || o_t !== 32'h0100_0000 || o_idx !== AW'(1) || o_err !== 1'b0 || o_cycles != e_cycles) begin
      errors++; $display("FAIL after_abort_scan: got hit=%b t=%h idx=%0d err=%b cycles=%0d expected 1 01000000 1 0 %0d",
                         o_hit, o_t, o_idx, o_err, o_cycles, e_cycles);
    end
    checks++;
    if (st_cyc_q.size() != 3 || done_cyc_q.size() != 1) begin
      errors++; $display("FAIL busy_start_dropped: got %0d launches %0d done pulses expected 3 1", st_cyc_q.size(), done_cyc_q.size());
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin mem[i] = '0; lat[i] = 1; rt[i] = '0; rc[i] = '0; end
    cur_ray = '0;
    test_reset();
    test_zero_count();
    test_single_hit();
    test_tie();
    test_misses();
    test_timeout();
    test_random();
    test_reset_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, %0d checks %0d errors so far", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/closest_hit_scheduler.md
CLOSEST_HIT_SCHEDULER -- requirements
Module: closest_hit_scheduler

Interface
REQ-001 Parameter TRIG_AW, default 8: triangle memory address width.
REQ-002 Parameter TIMEOUT, default 1024: maximum cycles to wait for ix_ready per triangle.
REQ-003 Parameter HIT_CODE, default 2'd1: ix_code value that means a valid intersection.
REQ-004 clock  in  1: single clock; all state changes on its rising edge.
REQ-005 reset  in  1: asynchronous, active-low reset.
REQ-006 start  in  1: one-cycle request to scan for one ray; ignored while busy=1.
REQ-007 ray_in  in  192: {start.x,y,z, dir.x,y,z}, each a 32-bit signed fixed Q4.28 value.
REQ-008 trig_count  in  TRIG_AW+1: number of triangles to scan (0..2^TRIG_AW), sampled with start.
REQ-009 trig_rd / trig_addr  out  1 / TRIG_AW: triangle memory read strobe and address.
REQ-010 trig_data  in  288: {V1,V2,V3} as packed x,y,z points, valid exactly 1 cycle after trig_rd.
REQ-011 ix_start  out  1: one-cycle launch pulse to the intersection unit.
REQ-012 ix_ray / ix_v1 / ix_v2 / ix_v3  out  192/96/96/96: registered operands, stable from ix_start until the result is consumed.
REQ-013 ix_ready / ix_t / ix_code  in  1/32/2: intersection result; ix_t and ix_code are valid in any cycle with ix_ready=1.
REQ-014 busy  out  1: high from the cycle after an accepted start until the cycle after done.
REQ-015 done  out  1: one-cycle pulse when the scan completes.
REQ-016 hit / hit_t / hit_index / err  out  1/32/TRIG_AW/1: scan result, held stable from done until the next accepted start.

Function
REQ-017 States: IDLE, FETCH, LOAD, LAUNCH, WAIT, UPDATE, DONE.
REQ-018 IDLE: start=1 latches ray_in, trig_count, clears idx, best_t=32'h7FFFFFFF, hit, err, then goes to FETCH; if trig_count=0, goes to DONE instead.
REQ-019 FETCH: trig_rd=1 and trig_addr=idx for exactly one cycle, then LOAD.
REQ-020 LOAD: captures trig_data into ix_v1..ix_v3, then LAUNCH.
REQ-021 LAUNCH: ix_start=1 for exactly one cycle, timeout counter cleared, then WAIT.
REQ-022 WAIT: ix_ready is sampled from the first cycle after ix_start; ix_ready=1 latches ix_t/ix_code and goes to UPDATE. When the counter reaches TIMEOUT, err is set to 1, the triangle is treated as a miss, and the FSM goes to UPDATE.
REQ-023 UPDATE: a candidate is a hit iff code==HIT_CODE, signed t>0, and t<best_t (strict, so ties keep the lower index). A hit updates best_t, hit_index=idx and hit=1.
REQ-024 UPDATE: if idx==trig_count-1, go to DONE; otherwise increment idx and go to FETCH.
REQ-025 DONE: done=1 for one cycle, hit_t=best_t, then IDLE.
REQ-026 ix_ready pulses outside WAIT are ignored; start in any state other than IDLE is dropped, not queued.
REQ-027 Per-triangle latency without timeout = 4 cycles + intersection latency.

Reset
REQ-028 reset=0 at any time forces IDLE immediately.
REQ-029 While reset=0, all outputs are 0 except hit_t, which is 32'h7FFFFFFF.
REQ-030 Reset aborts an in-flight scan with no done pulse; a late ix_ready after reset release is ignored.

Verification
REQ-031 trig_count=0, start -> done 2 cycles after start; hit=0, hit_t=7FFFFFFF; no trig_rd or ix_start.
REQ-032 One triangle (0,0,0),(2,0,0),(0,2,0); ray start (0.5,0.5,0.5), dir (0,0,-1); model returns code=1, t=08000000 -> hit=1, hit_t=08000000, hit_index=0, err=0.
REQ-033 Three triangles; model returns t=20000000/08000000/08000000, code=1 each -> hit_index=1 (tie keeps the first); exactly 3 ix_start pulses; trig_addr sequence is 0,1,2.
REQ-034 All triangles return code=0 or code=2, or code=1 with t<=0 -> hit=0, hit_t=7FFFFFFF.
REQ-035 TIMEOUT=16; ix_ready withheld for triangle 0, triangle 1 hits with t=10000000 -> err=1, hit_index=1; WAIT lasts exactly 16 cycles.
REQ-036 reset pulsed low during WAIT, then start asserted mid-scan after recovery -> outputs return to reset values with no done; start during busy is ignored; the next start in IDLE is served normally.
